// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, run/lap/pause/done FSM and 1 s count tick.
// Optional long-press clear on lap/reset is enabled by defining STOPWATCH_CTRL_LONGPRESS_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic       finish,
    output logic       run,
    output logic       tick,
    output logic       clr_n,
    output logic       hold,
    output logic       done,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int BTN_SS = 0;
    localparam int BTN_LR = 1;
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q, deb_q, press_q;
    logic [DEB_W-1:0] deb_cnt_q [2];

    state_e           state_q, state_d;
    logic             run_q, run_d, hold_q, done_q, clr_n_q, tick_q;
    logic             clr_req, count_en, long_fire;
    logic [DIV_W-1:0] div_q;

    assign raw = {btn_lr, btn_ss};

    // Debouncer: the level flips only after DEB_CYCLES consecutive mismatching cycles;
    // press_q is the one-cycle 0->1 event seen by the FSM on the following edge.
    // NOTE: every sequential process uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int b = 0; b < 2; b++) deb_cnt_q[b] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int b = 0; b < 2; b++) begin
                press_q[b] <= 1'b0;
                if (sync2_q[b] == deb_q[b]) begin
                    deb_cnt_q[b] <= '0;
                end else if (deb_cnt_q[b] == DEB_LAST) begin
                    deb_q[b]     <= sync2_q[b];
                    deb_cnt_q[b] <= '0;
                    press_q[b]   <= sync2_q[b];
                end else begin
                    deb_cnt_q[b] <= deb_cnt_q[b] + DEB_W'(1);
                end
            end
        end
    end

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_q;
    logic              long_armed_q, long_active;

    assign long_active = deb_q[BTN_LR] && long_armed_q
                         && (state_q inside {S_RUN, S_LAP, S_PAUSE});
    assign long_fire   = long_active && (long_q == LONG_LAST);

    // Fires once per hold; re-arms only after the debounced button is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            long_q       <= '0;
            long_armed_q <= 1'b1;
        end else begin
            if (!deb_q[BTN_LR]) long_armed_q <= 1'b1;
            else if (long_fire) long_armed_q <= 1'b0;
            long_q <= (long_active && !long_fire) ? long_q + LONG_W'(1) : '0;
        end
    end
`else
    logic unused_long_cycles;
    assign unused_long_cycles = ^LONG_CYCLES;
    assign long_fire          = 1'b0;
`endif

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        clr_req = 1'b0;
        if (finish) begin
            state_d = S_DONE;
        end else if (long_fire) begin
            state_d = S_IDLE;
            clr_req = 1'b1;
        end else if (press_q[BTN_SS]) begin
            case (state_q)
                S_IDLE, S_PAUSE: state_d = S_RUN;
                S_RUN, S_LAP:    state_d = S_PAUSE;
                default:         ;
            endcase
        end else if (press_q[BTN_LR]) begin
            case (state_q)
                S_RUN:   state_d = S_LAP;
                S_LAP:   state_d = S_RUN;
                default: begin
                    state_d = S_IDLE;
                    clr_req = 1'b1;
                end
            endcase
        end
        run_d    = (state_d == S_RUN) || (state_d == S_LAP);
        count_en = run_q && run_d;
    end

    // The divider only advances across edges where the counter runs before and after,
    // so a pause keeps the fractional second and the first tick lands TICK_DIV cycles in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_n_q <= 1'b0;
            tick_q  <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            hold_q  <= (state_d == S_LAP);
            done_q  <= (state_d == S_DONE);
            clr_n_q <= !clr_req;
            tick_q  <= 1'b0;
            if (clr_req || state_d == S_DONE) begin
                div_q <= '0;
            end else if (count_en) begin
                if (div_q == DIV_LAST) begin
                    div_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    assign run   = run_q;
    assign tick  = tick_q;
    assign clr_n = clr_n_q;
    assign hold  = hold_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: table-driven behavioural model compared every
// cycle, plus directed windows with hand-computed latencies and counts.
module tb_stopwatch_ctrl;
    localparam int TICK_DIV    = 10;
    localparam int DEB_CYCLES  = 4;
    localparam int LONG_CYCLES = 40;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       finish = 1'b0;
    logic       run, tick, clr_n, hold, done;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES),
        .LONG_CYCLES(LONG_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .btn_ss(btn_ss),
        .btn_lr(btn_lr),
        .finish(finish),
        .run   (run),
        .tick  (tick),
        .clr_n (clr_n),
        .hold  (hold),
        .done  (done),
        .state (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model. States: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP, 4 DONE.
    int ss_next [5] = '{1, 2, 1, 2, 4};
    int lr_next [5] = '{0, 3, 0, 1, 0};
    int lr_clr  [5] = '{1, 0, 1, 0, 1};
    int m_s1 [2] = '{0, 0};
    int m_s2 [2] = '{0, 0};
    int m_deb[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};
    int m_ev [2] = '{0, 0};
    int st   = 0;
    int frac = 0;
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
    int held  = 0;
    int armed = 1;
`endif
    int e_state = 0, e_run = 0, e_tick = 0, e_clr_n = 0, e_hold = 0, e_done = 0;

    function automatic bit counting(input int s);
        return (s == 1) || (s == 3);
    endfunction

    task automatic model_step();
        int  nxt;
        bit  clr;
        bit  fire;
        int  raw[2];
        raw[0] = int'(btn_ss);
        raw[1] = int'(btn_lr);
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_cnt[b] = 0; m_ev[b] = 0;
            end
            st = 0; frac = 0;
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
            held = 0; armed = 1;
`endif
            e_state = 0; e_run = 0; e_tick = 0; e_clr_n = 0; e_hold = 0; e_done = 0;
            return;
        end
        fire = 1'b0;
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
        if (m_deb[1] == 1 && armed == 1 && st >= 1 && st <= 3) begin
            held++;
            if (held == LONG_CYCLES) begin
                fire = 1'b1; held = 0; armed = 0;
            end
        end else begin
            held = 0;
        end
        if (m_deb[1] == 0) armed = 1;
`endif
        nxt = st;
        clr = 1'b0;
        if (finish)         nxt = 4;
        else if (fire)      begin nxt = 0; clr = 1'b1; end
        else if (m_ev[0] != 0) nxt = ss_next[st];
        else if (m_ev[1] != 0) begin nxt = lr_next[st]; clr = (lr_clr[st] != 0); end

        e_tick = 0;
        if (clr || nxt == 4) frac = 0;
        else if (counting(st) && counting(nxt)) begin
            frac++;
            if (frac == TICK_DIV) begin frac = 0; e_tick = 1; end
        end
        st      = nxt;
        e_state = nxt;
        e_run   = counting(nxt);
        e_hold  = (nxt == 3);
        e_done  = (nxt == 4);
        e_clr_n = clr ? 0 : 1;

        for (int b = 0; b < 2; b++) begin
            m_ev[b] = 0;
            if (m_s2[b] != m_deb[b]) begin
                m_cnt[b]++;
                if (m_cnt[b] == DEB_CYCLES) begin
                    m_deb[b] = m_s2[b];
                    m_cnt[b] = 0;
                    m_ev[b]  = m_deb[b];
                end
            end else begin
                m_cnt[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        check("state", 32'(state), 32'(e_state));
        check("run",   32'(run),   32'(e_run));
        check("tick",  32'(tick),  32'(e_tick));
        check("clr_n", 32'(clr_n), 32'(e_clr_n));
        check("hold",  32'(hold),  32'(e_hold));
        check("done",  32'(done),  32'(e_done));
    end

    // Drives the buttons from the current negedge; index k means the negedge after the
    // k-th rising edge, counting the first edge that samples the new inputs as k=1.
    task automatic run_window(input int ss_len, input int lr_len, input int n, input int tgt,
                              output int st_idx, output int idle_idx, output int tk_idx,
                              output int tk_cnt, output int clr_cnt);
        st_idx = -1; idle_idx = -1; tk_idx = -1; tk_cnt = 0; clr_cnt = 0;
        btn_ss = (ss_len > 0);
        btn_lr = (lr_len > 0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (k == ss_len) btn_ss = 1'b0;
            if (k == lr_len) btn_lr = 1'b0;
            if (st_idx < 0 && int'(state) == tgt) st_idx = k;
            if (idle_idx < 0 && state == 3'd0) idle_idx = k;
            if (tick) begin
                tk_cnt++;
                if (tk_idx < 0) tk_idx = k;
            end
            if (!clr_n) clr_cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int si, ii, ti, tc, cc;
        bit found;

        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_state", 32'(state), 0);
        check("rst_clr_n", 32'(clr_n), 0);
        check("rst_run",   32'(run),   0);
        reset = 1'b1;
        @(negedge clock);
        check("rel_clr_n", 32'(clr_n), 1);

        run_window(3, 0, 15, 0, si, ii, ti, tc, cc);
        check("glitch_state", 32'(state), 0);
        check("glitch_clr",   32'(cc),    0);

        run_window(10, 0, 25, 1, si, ii, ti, tc, cc);
        check("start_latency",   32'(si), 7);
        check("first_tick_idx",  32'(ti), 17);
        check("start_clr",       32'(cc), 0);
        run_window(0, 0, 30, 1, si, ii, ti, tc, cc);
        check("tick_period_cnt", 32'(tc), 3);

        run_window(0, 5, 14, 3, si, ii, ti, tc, cc);
        check("lap_latency", 32'(si), 7);
        check("lap_hold",    32'(hold), 1);
        run_window(0, 0, 20, 3, si, ii, ti, tc, cc);
        check("lap_ticks",   32'(tc), 2);
        run_window(0, 5, 14, 1, si, ii, ti, tc, cc);
        check("unlap_latency", 32'(si), 7);
        check("unlap_hold",    32'(hold), 0);

        found = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            @(negedge clock);
            if (tick) found = 1'b1;
        end
        check("align_tick", 32'(found), 1);
        run_window(5, 0, 30, 2, si, ii, ti, tc, cc);
        check("pause_latency", 32'(si), 7);
        check("pause_ticks",   32'(tc), 0);
        run_window(5, 0, 20, 1, si, ii, ti, tc, cc);
        check("resume_latency",   32'(si), 7);
        check("resume_tick_idx",  32'(ti), 11);

        run_window(5, 0, 14, 2, si, ii, ti, tc, cc);
        check("pause2_latency", 32'(si), 7);
        run_window(0, 5, 14, 0, si, ii, ti, tc, cc);
        check("pause_clear_latency", 32'(si), 7);
        check("pause_clear_pulses",  32'(cc), 1);

        run_window(5, 0, 14, 1, si, ii, ti, tc, cc);
        check("run_again", 32'(si), 7);
        finish = 1'b1;
        run_window(0, 0, 1, 4, si, ii, ti, tc, cc);
        check("finish_latency", 32'(si), 1);
        check("finish_run",     32'(run),  0);
        check("finish_done",    32'(done), 1);
        run_window(0, 5, 14, 4, si, ii, ti, tc, cc);
        check("done_lr_ignored", 32'(state), 4);
        check("done_lr_noclr",   32'(cc),    0);
        finish = 1'b0;
        run_window(5, 0, 14, 4, si, ii, ti, tc, cc);
        check("done_ss_ignored", 32'(state), 4);
        run_window(0, 5, 14, 0, si, ii, ti, tc, cc);
        check("done_clear_latency", 32'(si), 7);
        check("done_clear_pulses",  32'(cc), 1);

        run_window(5, 0, 14, 1, si, ii, ti, tc, cc);
        check("run_before_both", 32'(si), 7);
        run_window(5, 5, 14, 2, si, ii, ti, tc, cc);
        check("both_to_pause", 32'(si), 7);
        check("both_noclr",    32'(cc), 0);

        run_window(5, 0, 14, 1, si, ii, ti, tc, cc);
        check("run_before_hold", 32'(si), 7);
        run_window(0, 60, 80, 3, si, ii, ti, tc, cc);
        check("hold_lap_latency", 32'(si), 7);
`ifdef STOPWATCH_CTRL_LONGPRESS_EN
        check("long_idle_idx", 32'(ii),    46);
        check("long_clr",      32'(cc),    1);
        check("long_state",    32'(state), 0);
`else
        check("long_no_idle",  32'(ii),    32'hFFFF_FFFF);
        check("long_clr",      32'(cc),    0);
        check("long_state",    32'(state), 3);
`endif

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control sequencer for the six-digit stopwatch counter datapath.
- Debounces two raw pushbuttons (start/stop, lap/reset), runs the stopwatch state machine and generates the 1 s count-enable tick.
- Drives the counter's run enable, clear, display-hold and done indications; the counter itself only increments on `tick`.

Parameters:
- TICK_DIV, 50000000, clock cycles per count tick (1 s at 50 MHz); minimum 2.
- DEB_CYCLES, 1000000, consecutive stable synchronized cycles before a button level is accepted (20 ms); minimum 1.
- LONG_CYCLES, 100000000, lap/reset hold time for long-press clear (optional feature only).

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous active-low reset.
- btn_ss, in, 1, raw start/stop button, active-high, asynchronous.
- btn_lr, in, 1, raw lap/reset button, active-high, asynchronous.
- finish, in, 1, level; forces DONE while high.
- run, out, 1, counter enable; high in RUN and LAP.
- tick, out, 1, one-cycle count pulse, only while run=1.
- clr_n, out, 1, active-low counter clear, one-cycle pulse.
- hold, out, 1, display freeze; high only in LAP.
- done, out, 1, high in DONE.
- state, out, 3, IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4.

Behaviour:
- Reset (reset=0, async):
  - State=IDLE; run=0, tick=0, hold=0, done=0.
  - clr_n=0, so the counter is held clear for the whole reset; clr_n goes to 1 on the first rising edge after release.
  - Debounce and tick counters go to 0.
- Button path, identical per button:
  - 2-flop synchronizer, then a stability counter.
  - The counter increments while the synced level differs from the debounced level and clears when they match.
  - When the count reaches DEB_CYCLES-1 with the mismatch still present, the debounced level flips on the next edge.
  - A press event is a debounced 0->1 transition, one cycle wide. Release generates no event.
  - Latency from the first edge sampling raw=1 to the FSM state change is DEB_CYCLES+3 rising edges.
  - A glitch shorter than DEB_CYCLES cycles produces no event.
- FSM, evaluated on press events (ss = start/stop, lr = lap/reset):
  - IDLE: ss->RUN. lr->IDLE with a clr pulse.
  - RUN: ss->PAUSE. lr->LAP (hold=1, counting continues).
  - LAP: lr->RUN (hold released). ss->PAUSE (hold released).
  - PAUSE: ss->RUN. lr->IDLE with a clr pulse.
  - DONE: outputs run=0 and done=1. lr with finish=0 ->IDLE with a clr pulse. ss is ignored.
  - finish=1 from any state -> DONE on the next edge; this has priority over all button events.
  - ss and lr events in the same cycle: ss wins, lr is discarded.
- All outputs are registered.
  - clr_n is low for exactly one cycle, on the same edge as the state update that requests it.
- Tick divider:
  - Counts 0..TICK_DIV-1 only while the next state has run=1.
  - tick=1 in the cycle after the divider holds TICK_DIV-1; the divider then wraps to 0.
  - PAUSE and LAP->PAUSE freeze the divider, preserving the fractional second.
  - A clr pulse or DONE resets the divider to 0.
  - The first tick after IDLE->RUN arrives TICK_DIV cycles after the transition.

Optional Feature:
- Macro: STOPWATCH_CTRL_LONGPRESS_EN.
- Defined:
  - If the debounced lr level stays high for LONG_CYCLES consecutive cycles in RUN, LAP or PAUSE, the FSM goes to IDLE with a clr pulse.
  - This fires once per hold; release is required before it can re-arm.
  - The short-press event issued when the press began still takes effect normally.
- Not defined: no long-press logic; LONG_CYCLES is unused.

Test Plan (TICK_DIV=10, DEB_CYCLES=4, LONG_CYCLES=40):
- Reset, then raw ss high for 10 cycles -> state=1 and run=1 exactly 7 edges after first sample; first tick 10 cycles later; ticks every 10 cycles.
- ss pulse of 3 cycles while in IDLE -> no state change, clr_n stays 1.
- RUN, lr press -> state=3, hold=1, ticks continue; lr again -> state=1, hold=0.
- RUN with divider at 6, ss press -> PAUSE, no ticks; ss again -> next tick after 4 more cycles; PAUSE then lr -> state=0, clr_n low exactly 1 cycle.
- finish=1 in RUN -> state=4, run=0, done=1 next edge; lr while finish=1 ignored; finish=0 then lr -> IDLE with clr pulse. ss and lr debounced on the same edge in RUN -> PAUSE.
- With STOPWATCH_CTRL_LONGPRESS_EN, RUN, hold lr for 60 cycles -> LAP, then IDLE plus one clr pulse 40 cycles after debounce; without the macro -> LAP only.
